inv_mix_cols_iter: RTL

- Iterative AES InvMixColumns engine for the decryption datapath. It is the inverse of the existing combinational MixColumns block.
- Accepts one 128-bit state over a valid/ready handshake and transforms COLS_PER_CYCLE columns per clock.
- Returns the result over a second valid/ready handshake. Sits between inverse ShiftRows/SubBytes and AddRoundKey in the iterative decrypt round.

---
 rtl/aes_pkg.sv | 80 ++++++++
 rtl/inv_mix_cols_iter_if.sv | 26 ++
 rtl/inv_mix_col.sv | 18 +
 rtl/inv_mix_cols_iter.sv | 119 +++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES GF(2^8) helpers for the decrypt datapath.
//   AES_POLY        reduction constant for x^8 + x^4 + x^3 + x + 1
//   xtime           multiply by 02
//   gmul09/0b/0d/0e constant multiplies built from xtime chains
//   get_col/set_col column extract/insert, FIPS-197 column-major order
//                   (column c at bits [127-32c -: 32], row 0 in the MSB byte)
package aes_pkg;

   localparam logic [7:0] AES_POLY = 8'h1B;

   typedef logic [127:0]    block_t;
   // Element 0 is the MSB byte, i.e. row 0 of the column.
   typedef logic [0:3][7:0] col_t;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} imc_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] gmul09(input logic [7:0] b);
      logic [7:0] b2, b4, b8;
      b2 = xtime(b);
      b4 = xtime(b2);
      b8 = xtime(b4);
      return b8 ^ b;
   endfunction

   function automatic logic [7:0] gmul0b(input logic [7:0] b);
      logic [7:0] b2, b4, b8;
      b2 = xtime(b);
      b4 = xtime(b2);
      b8 = xtime(b4);
      return b8 ^ b2 ^ b;
   endfunction

   function automatic logic [7:0] gmul0d(input logic [7:0] b);
      logic [7:0] b2, b4, b8;
      b2 = xtime(b);
      b4 = xtime(b2);
      b8 = xtime(b4);
      return b8 ^ b4 ^ b;
   endfunction

   function automatic logic [7:0] gmul0e(input logic [7:0] b);
      logic [7:0] b2, b4, b8;
      b2 = xtime(b);
      b4 = xtime(b2);
      b8 = xtime(b4);
      return b8 ^ b4 ^ b2;
   endfunction

   function automatic col_t get_col(input block_t s, input logic [1:0] c);
      col_t r;
      r = '0;
      case (c)
         2'd0: r = s[127:96];
         2'd1: r = s[95:64];
         2'd2: r = s[63:32];
         2'd3: r = s[31:0];
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic block_t set_col(input block_t s, input logic [1:0] c,
                                      input col_t v);
      block_t r;
      r = s;
      case (c)
         2'd0: r[127:96] = v;
         2'd1: r[95:64]  = v;
         2'd2: r[63:32]  = v;
         2'd3: r[31:0]   = v;
         default: r = s;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/inv_mix_cols_iter_if.sv
// inv_mix_cols_iter_if: input and output valid/ready channels of the
// InvMixColumns engine.
//   in_valid/in_ready/din     : state offered to the engine
//   out_valid/out_ready/dout  : transformed state returned by the engine
//   master : producer/consumer side, slave : engine side
interface inv_mix_cols_iter_if;
   import aes_pkg::*;

   logic   in_valid;
   logic   in_ready;
   block_t din;
   logic   out_valid;
   logic   out_ready;
   block_t dout;

   modport master (
      output in_valid, din, out_ready,
      input  in_ready, out_valid, dout
   );

   modport slave (
      input  in_valid, din, out_ready,
      output in_ready, out_valid, dout
   );

endinterface

// File: rtl/inv_mix_col.sv
// inv_mix_col: combinational InvMixColumns of one column.
//   in_col  : 4 bytes, row 0 first
//   out_col : o_r = 0e*i_r ^ 0b*i_(r+1) ^ 0d*i_(r+2) ^ 09*i_(r+3)
module inv_mix_col
   import aes_pkg::*;
(
   input  col_t in_col,
   output col_t out_col
);

   always_comb begin
      out_col[0] = gmul0e(in_col[0]) ^ gmul0b(in_col[1]) ^ gmul0d(in_col[2]) ^ gmul09(in_col[3]);
      out_col[1] = gmul0e(in_col[1]) ^ gmul0b(in_col[2]) ^ gmul0d(in_col[3]) ^ gmul09(in_col[0]);
      out_col[2] = gmul0e(in_col[2]) ^ gmul0b(in_col[3]) ^ gmul0d(in_col[0]) ^ gmul09(in_col[1]);
      out_col[3] = gmul0e(in_col[3]) ^ gmul0b(in_col[0]) ^ gmul0d(in_col[1]) ^ gmul09(in_col[2]);
   end

endmodule

// File: rtl/inv_mix_cols_iter.sv
// inv_mix_cols_iter: iterative AES InvMixColumns, COLS_PER_CYCLE (1, 2, 4)
// columns per clock.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of inv_mix_cols_iter_if (in/out valid-ready, din, dout)
// Accept in IDLE (or in DONE together with the output handshake), transform
// in place over 4/COLS_PER_CYCLE BUSY cycles, then hold the result in DONE.
module inv_mix_cols_iter
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input logic                clk,
   input logic                rst_n,
   inv_mix_cols_iter_if.slave bus
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
      $error("inv_mix_cols_iter: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam int unsigned NCOL     = COLS_PER_CYCLE;
   // For 4 columns per cycle the step truncates to 0, which is the wrap.
   localparam logic [1:0]  COL_STEP = 2'(COLS_PER_CYCLE);

   imc_state_e state_q, state_d;
   logic [1:0] col_q, col_d;
   block_t     work_q, work_d;
   logic       out_valid_q, out_valid_d;
   block_t     dout_q, dout_d;

   logic       in_ready;
   logic       last_col;
   block_t     work_busy;
   logic [1:0] cidx [NCOL];
   col_t       cin  [NCOL];
   col_t       cout [NCOL];

   // Each lane k works on column col+k this cycle.
   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
      assign cidx[g] = col_q + 2'(g);
      assign cin[g]  = get_col(work_q, cidx[g]);

      inv_mix_col u_col (
         .in_col  (cin[g]),
         .out_col (cout[g])
      );
   end

   always_comb begin
      work_busy = work_q;
      for (int unsigned k = 0; k < NCOL; k++) begin
         work_busy = set_col(work_busy, cidx[k], cout[k]);
      end
   end

   assign last_col = (int'(col_q) + COLS_PER_CYCLE) >= 4;
   assign in_ready = rst_n && ((state_q == IDLE) || (state_q == DONE && bus.out_ready));

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      work_d      = work_q;
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready) begin
               work_d  = bus.din;
               col_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            work_d = work_busy;
            col_d  = col_q + COL_STEP;
            if (last_col) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               dout_d      = work_busy;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (bus.in_valid) begin
                  work_d  = bus.din;
                  col_d   = '0;
                  state_d = BUSY;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         col_q       <= '0;
         work_q      <= '0;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         work_q      <= work_d;
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.dout      = dout_q;

endmodule
